// File: rtl/bin2bcd_seq_pkg.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq_pkg
//   Shared definitions for the sequential binary-to-BCD converter:
//   BCD digit width, the saturation digit value and the FSM state encoding.
//   Imported by bin2bcd_seq and bcd_digit_adj.
// -----------------------------------------------------------------------------
package bin2bcd_seq_pkg;

    // Width of one packed BCD digit.
    localparam int DIGIT_W = 4;

    // Digit value used to saturate the output on overflow.
    localparam logic [DIGIT_W-1:0] BCD_NINE = 4'h9;

    // Conversion FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADJ   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage : bin2bcd_seq_pkg

// File: rtl/bin2bcd_seq_bcd_digit_adj.sv
// -----------------------------------------------------------------------------
// bcd_digit_adj
//   Combinational add-3 correction for one BCD digit of the double-dabble
//   shift register: a digit of 5 or more gets +3 so that the following left
//   shift carries correctly into the next decimal digit.
//   Ports:
//     digit     in   DIGIT_W   digit before correction
//     adjusted  out  DIGIT_W   corrected digit (4-bit result, no carry out)
// -----------------------------------------------------------------------------
module bcd_digit_adj
    import bin2bcd_seq_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] adjusted
);

    assign adjusted = (digit > DIGIT_W'(4)) ? (digit + DIGIT_W'(3)) : digit;

endmodule : bcd_digit_adj

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
//   Sequential binary-to-BCD converter (shift-add-3 / double dabble) with a
//   start/done handshake. One conversion takes 2*DATA_W+2 cycles from the
//   accepting edge to the next possible accepting edge; results are held
//   between done pulses. Optional two's-complement input (magnitude is
//   converted, sign reported on neg), overflow saturation to all 9s, and a
//   leading-zero mask for the LCD digit renderer.
//   Parameters:
//     DATA_W  binary input width (4..32)
//     DIGITS  number of BCD digits produced (1..10)
//     SIGNED  1: data is two's complement
//   Ports:
//     sys_clk    in   1          clock, rising edge
//     sys_rst_n  in   1          asynchronous active-low reset
//     start      in   1          conversion request, honoured only when idle
//     data       in   DATA_W     value captured on the accepting edge
//     busy       out  1          conversion in progress
//     done       out  1          one-cycle pulse, results valid and held
//     bcd        out  4*DIGITS   packed BCD, digit 0 (units) in bits [3:0]
//     neg        out  1          input was negative (SIGNED=1 only)
//     ovf        out  1          magnitude >= 10^DIGITS, bcd saturated
//     lz_mask    out  DIGITS     bit i set: digit i and all above are zero
// -----------------------------------------------------------------------------
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DIGITS = 5,
    parameter int SIGNED = 0
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst_n,
    input  logic                        start,
    input  logic [DATA_W-1:0]           data,
    output logic                        busy,
    output logic                        done,
    output logic [DIGIT_W*DIGITS-1:0]   bcd,
    output logic                        neg,
    output logic                        ovf,
    output logic [DIGITS-1:0]           lz_mask
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int SR_W  = BCD_W + DATA_W;
    localparam int CNT_W = $clog2(DATA_W);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    state_t              state;
    state_t              next_state;

    logic [SR_W-1:0]     sr;
    logic [SR_W-1:0]     sr_adj;
    logic [CNT_W-1:0]    cnt;
    logic                sticky;
    logic                sign_q;

    logic [DATA_W-1:0]   mag;
    logic                sign_d;
    logic [DIGITS-1:0]   lz_next;

    logic                load;
    logic                adj_en;
    logic                shift_en;
    logic                finish;

    // ------------------------------------------------------------------
    // Input magnitude. The most negative value negates to 2^(DATA_W-1),
    // which still fits in DATA_W unsigned bits, so no wrap occurs.
    // ------------------------------------------------------------------
    assign sign_d = (SIGNED != 0) && data[DATA_W-1];

    always_comb begin
        mag = data;
        if (sign_d) begin
            mag = ~data + DATA_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Add-3 correction of every BCD digit; the binary part passes through.
    // ------------------------------------------------------------------
    assign sr_adj[DATA_W-1:0] = sr[DATA_W-1:0];

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit    (sr[DATA_W + DIGIT_W*g +: DIGIT_W]),
            .adjusted (sr_adj[DATA_W + DIGIT_W*g +: DIGIT_W])
        );
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: default assignment first so every path drives next_state;
        // otherwise a missed branch would infer a latch.
        next_state = state;
        unique case (state)
            ST_IDLE:  if (start) next_state = ST_ADJ;
            ST_ADJ:   next_state = ST_SHIFT;
            ST_SHIFT: next_state = (cnt == CNT_LAST) ? ST_DONE : ST_ADJ;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: control strobes decoded from the current state
    // ------------------------------------------------------------------
    always_comb begin
        load     = 1'b0;
        adj_en   = 1'b0;
        shift_en = 1'b0;
        finish   = 1'b0;
        unique case (state)
            ST_IDLE:  load     = start;
            ST_ADJ:   adj_en   = 1'b1;
            ST_SHIFT: shift_en = 1'b1;
            ST_DONE:  finish   = 1'b1;
            default:  ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: shift register, bit counter, overflow sticky, sign.
    // ------------------------------------------------------------------
    // NOTE: the working registers are reset too, even though a load always
    // overwrites them, so the block comes out of reset in a fully defined
    // state and an aborted conversion leaves nothing behind.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sr     <= '0;
            cnt    <= '0;
            sticky <= 1'b0;
            sign_q <= 1'b0;
        end else if (load) begin
            sr     <= {{BCD_W{1'b0}}, mag};
            cnt    <= '0;
            sticky <= 1'b0;
            sign_q <= sign_d;
        end else if (adj_en) begin
            sr     <= sr_adj;
        end else if (shift_en) begin
            sr     <= {sr[SR_W-2:0], 1'b0};
            // A one leaving the top digit means the value no longer fits.
            sticky <= sticky | sr[SR_W-1];
            cnt    <= cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero mask from the finished BCD field. Bit 0 stays 0 so the
    // units digit is always rendered.
    // ------------------------------------------------------------------
    always_comb begin
        logic all_zero;
        lz_next  = '0;
        // NOTE: blocking assignments here build a running AND from the top
        // digit downwards within one evaluation; sequential blocks use <=.
        all_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            all_zero   = all_zero && (sr[DATA_W + DIGIT_W*i +: DIGIT_W] == '0);
            lz_next[i] = all_zero;
        end
    end

    // ------------------------------------------------------------------
    // Result and handshake registers; results hold until the next done.
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd     <= '0;
            neg     <= 1'b0;
            ovf     <= 1'b0;
            lz_mask <= '0;
        end else begin
            done <= finish;
            if (load) begin
                busy <= 1'b1;
            end else if (finish) begin
                busy <= 1'b0;
            end
            if (finish) begin
                bcd     <= sticky ? {DIGITS{BCD_NINE}} : sr[SR_W-1:DATA_W];
                ovf     <= sticky;
                neg     <= sign_q;
                lz_mask <= sticky ? '0 : lz_next;
            end
        end
    end

endmodule : bin2bcd_seq

// File: tb/tb_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin2bcd_seq
//   Self-checking bench for bin2bcd_seq. Three instances share one clock and
//   reset: unsigned 16-bit/5 digits, signed 16-bit/5 digits, and unsigned
//   16-bit/4 digits (overflow possible). Expected results come from a decimal
//   arithmetic model (repeated division by ten, powers of ten).
// -----------------------------------------------------------------------------
module tb_bin2bcd_seq;

    logic        sys_clk;
    logic        sys_rst_n;

    // unsigned, 5 digits
    logic        m_start, m_busy, m_done, m_neg, m_ovf;
    logic [15:0] m_data;
    logic [19:0] m_bcd;
    logic [4:0]  m_lz_mask;

    // signed, 5 digits
    logic        s_start, s_busy, s_done, s_neg, s_ovf;
    logic [15:0] s_data;
    logic [19:0] s_bcd;
    logic [4:0]  s_lz_mask;

    // unsigned, 4 digits
    logic        n_start, n_busy, n_done, n_neg, n_ovf;
    logic [15:0] n_data;
    logic [15:0] n_bcd;
    logic [3:0]  n_lz_mask;

    int vectors;
    int miscompares;

    int          t_done [3];
    int          ndone;
    int          cyc;
    int          first_done;
    logic [15:0] rval;

    bin2bcd_seq #(.DATA_W(16), .DIGITS(5), .SIGNED(0)) u_main (
        .sys_clk (sys_clk), .sys_rst_n (sys_rst_n),
        .start (m_start), .data (m_data), .busy (m_busy), .done (m_done),
        .bcd (m_bcd), .neg (m_neg), .ovf (m_ovf), .lz_mask (m_lz_mask)
    );

    bin2bcd_seq #(.DATA_W(16), .DIGITS(5), .SIGNED(1)) u_signed (
        .sys_clk (sys_clk), .sys_rst_n (sys_rst_n),
        .start (s_start), .data (s_data), .busy (s_busy), .done (s_done),
        .bcd (s_bcd), .neg (s_neg), .ovf (s_ovf), .lz_mask (s_lz_mask)
    );

    bin2bcd_seq #(.DATA_W(16), .DIGITS(4), .SIGNED(0)) u_narrow (
        .sys_clk (sys_clk), .sys_rst_n (sys_rst_n),
        .start (n_start), .data (n_data), .busy (n_busy), .done (n_done),
        .bcd (n_bcd), .neg (n_neg), .ovf (n_ovf), .lz_mask (n_lz_mask)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Decimal reference: digits by repeated division, overflow and leading
    // zeros by comparison against powers of ten.
    task automatic model(input longint unsigned mag, input int digits,
                         output logic [63:0] exp_bcd, output logic exp_ovf,
                         output logic [63:0] exp_lz);
        longint unsigned pw;
        longint unsigned v;
        pw = 1;
        for (int i = 0; i < digits; i++) pw = pw * 10;
        exp_ovf = (mag >= pw);
        exp_bcd = '0;
        exp_lz  = '0;
        if (exp_ovf) begin
            for (int i = 0; i < digits; i++) exp_bcd[4*i +: 4] = 4'h9;
        end else begin
            v = mag;
            for (int i = 0; i < digits; i++) begin
                exp_bcd[4*i +: 4] = 4'(v % 10);
                v = v / 10;
            end
            pw = 10;
            for (int i = 1; i < digits; i++) begin
                exp_lz[i] = (mag < pw);
                pw = pw * 10;
            end
        end
    endtask

    task automatic drive(input int sel, input logic st, input logic [15:0] d);
        case (sel)
            0:       begin m_start = st; m_data = d; end
            1:       begin s_start = st; s_data = d; end
            default: begin n_start = st; n_data = d; end
        endcase
    endtask

    task automatic sample(input int sel, output logic o_done, output logic o_busy,
                          output logic [63:0] o_bcd, output logic o_neg,
                          output logic o_ovf, output logic [63:0] o_lz);
        case (sel)
            0: begin
                o_done = m_done; o_busy = m_busy; o_bcd = 64'(m_bcd);
                o_neg = m_neg; o_ovf = m_ovf; o_lz = 64'(m_lz_mask);
            end
            1: begin
                o_done = s_done; o_busy = s_busy; o_bcd = 64'(s_bcd);
                o_neg = s_neg; o_ovf = s_ovf; o_lz = 64'(s_lz_mask);
            end
            default: begin
                o_done = n_done; o_busy = n_busy; o_bcd = 64'(n_bcd);
                o_neg = n_neg; o_ovf = n_ovf; o_lz = 64'(n_lz_mask);
            end
        endcase
    endtask

    // One conversion on instance sel, entered and left just after a falling
    // edge with the instance idle. Checks latency and all results.
    task automatic run(input int sel, input logic [15:0] val);
        longint unsigned mag;
        logic [63:0]     exp_bcd, exp_lz, o_bcd, o_lz;
        logic            exp_ovf, exp_neg, o_done, o_busy, o_neg, o_ovf;
        int              digits;
        int              lat;
        string           tag;

        tag     = $sformatf("dut%0d val=0x%04h", sel, val);
        digits  = (sel == 2) ? 4 : 5;
        mag     = longint'(val);
        exp_neg = 1'b0;
        if (sel == 1 && val[15]) begin
            mag     = 65536 - longint'(val);
            exp_neg = 1'b1;
        end
        model(mag, digits, exp_bcd, exp_ovf, exp_lz);

        drive(sel, 1'b1, val);
        @(negedge sys_clk);
        // Changing data after acceptance must not disturb the result.
        drive(sel, 1'b0, ~val);
        sample(sel, o_done, o_busy, o_bcd, o_neg, o_ovf, o_lz);
        check({tag, " busy"}, 64'(o_busy), 64'd1);

        lat = 0;
        while (!o_done && lat < 100) begin
            @(negedge sys_clk);
            lat++;
            sample(sel, o_done, o_busy, o_bcd, o_neg, o_ovf, o_lz);
        end
        check({tag, " latency"}, 64'(lat), 64'd33);
        check({tag, " bcd"},     o_bcd,    exp_bcd);
        check({tag, " ovf"},     64'(o_ovf), 64'(exp_ovf));
        check({tag, " neg"},     64'(o_neg), 64'(exp_neg));
        check({tag, " lz_mask"}, o_lz,     exp_lz);
        check({tag, " busy_end"}, 64'(o_busy), 64'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        sys_rst_n   = 1'b0;
        m_start = 1'b0; m_data = '0;
        s_start = 1'b0; s_data = '0;
        n_start = 1'b0; n_data = '0;

        repeat (3) @(negedge sys_clk);
        check("reset m_busy", 64'(m_busy), 64'd0);
        check("reset m_done", 64'(m_done), 64'd0);
        check("reset m_bcd",  64'(m_bcd),  64'd0);
        check("reset m_ovf",  64'(m_ovf),  64'd0);
        check("reset m_lz",   64'(m_lz_mask), 64'd0);
        check("reset s_neg",  64'(s_neg),  64'd0);
        check("reset n_bcd",  64'(n_bcd),  64'd0);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        // Directed unsigned, 5 digits
        run(0, 16'd65535);
        run(0, 16'd0);
        run(0, 16'd907);
        run(0, 16'd9999);
        run(0, 16'd10);
        run(0, 16'd1);

        // Directed signed
        run(1, 16'h8000);
        run(1, 16'hFFFF);
        run(1, 16'h0000);
        run(1, 16'h7FFF);
        run(1, 16'hD8F1);

        // Directed 4 digits (overflow boundary)
        run(2, 16'd12345);
        run(2, 16'd9999);
        run(2, 16'd10000);
        run(2, 16'd0);
        run(2, 16'd65535);

        // Random values on all three instances
        for (int i = 0; i < 12; i++) begin
            rval = 16'($urandom);
            run(0, rval);
            rval = 16'($urandom);
            run(1, rval);
            rval = 16'($urandom_range(0, 20000));
            run(2, rval);
        end

        // start pulses while busy are ignored: exactly one done at edge 33
        m_data = 16'd4321;
        m_start = 1'b1;
        @(negedge sys_clk);
        ndone = 0;
        first_done = -1;
        for (int c = 1; c <= 70; c++) begin
            m_start = (c == 5 || c == 20);
            m_data  = 16'(c);
            @(negedge sys_clk);
            if (m_done) begin
                ndone++;
                if (first_done < 0) first_done = c;
            end
        end
        m_start = 1'b0;
        check("ignored start done count", 64'(ndone), 64'd1);
        check("ignored start latency", 64'(first_done), 64'd33);
        check("ignored start bcd", 64'(m_bcd), 64'h04321);

        // start held high: back-to-back conversions every 34 cycles
        m_data  = 16'd31415;
        m_start = 1'b1;
        cyc   = 0;
        ndone = 0;
        while (ndone < 3 && cyc < 200) begin
            @(negedge sys_clk);
            cyc++;
            if (m_done) begin
                t_done[ndone] = cyc;
                ndone++;
            end
        end
        m_start = 1'b0;
        check("held start done count", 64'(ndone), 64'd3);
        if (ndone == 3) begin
            check("held start first done", 64'(t_done[0]), 64'd34);
            check("held start period 1", 64'(t_done[1] - t_done[0]), 64'd34);
            check("held start period 2", 64'(t_done[2] - t_done[1]), 64'd34);
        end
        check("held start bcd", 64'(m_bcd), 64'h31415);

        // Reset in the middle of a conversion aborts it without done
        m_data  = 16'd12345;
        m_start = 1'b1;
        @(negedge sys_clk);
        m_start = 1'b0;
        repeat (10) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        check("abort busy", 64'(m_busy), 64'd0);
        check("abort done", 64'(m_done), 64'd0);
        check("abort bcd",  64'(m_bcd),  64'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge sys_clk);
            if (m_done) ndone++;
        end
        check("abort no done", 64'(ndone), 64'd0);
        check("abort idle busy", 64'(m_busy), 64'd0);
        run(0, 16'd42);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_bin2bcd_seq
